// File: rtl/ps2_kbd_decoder.sv
// PS/2 scan code set 2 decoder: prefixes, modifier/lock tracking, show-ahead event FIFO.
// Optional LED update protocol (ED + lock byte, 0xFA acks) enabled by defining PS2_KBD_LED_EN.
module ps2_kbd_decoder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 2000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       rx_error,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  input  logic       ev_pop,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic [3:0] mods,
  output logic [2:0] locks
`ifdef PS2_KBD_LED_EN
  ,
  output logic [7:0] tx_data,
  output logic       send_req,
  input  logic       tx_busy
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_E1SKIP} dec_state_t;

  dec_state_t st_q;
  logic [2:0] cnt_q;
  logic       rdy_q;
  logic       take, byte_ok, led_eat, dec_byte;
  logic       is_status;
  logic       evt_we, evt_ext, evt_brk;
  logic [7:0] evt_code;
  logic [3:0] mods_q;
  logic [2:0] locks_q, held_q, lk_sel, lock_tgl;
  logic       ovf_q;

  assign take     = rx_ready & ~rdy_q;
  assign byte_ok  = take & ~rx_error;
  assign dec_byte = byte_ok & ~led_eat;

  assign is_status = (rx_data == 8'hAA) || (rx_data == 8'hFC) || (rx_data == 8'hFA) ||
                     (rx_data == 8'hFE) || (rx_data == 8'hEE) || (rx_data == 8'h00) ||
                     (rx_data == 8'hFF);

  // Event is produced combinationally so it lands in the FIFO on the edge its last byte is taken
  always_comb begin
    evt_we   = 1'b0;
    evt_ext  = 1'b0;
    evt_brk  = 1'b0;
    evt_code = rx_data;
    if (dec_byte) begin
      case (st_q)
        S_IDLE:   evt_we = (rx_data != 8'hE0) && (rx_data != 8'hF0) && (rx_data != 8'hE1) && !is_status;
        S_E0: begin
          evt_we  = (rx_data != 8'hF0);
          evt_ext = 1'b1;
        end
        S_F0: begin
          evt_we  = 1'b1;
          evt_brk = 1'b1;
        end
        S_E0F0: begin
          evt_we  = 1'b1;
          evt_ext = 1'b1;
          evt_brk = 1'b1;
        end
        S_E1SKIP: begin
          evt_we   = (cnt_q == 3'd6);
          evt_ext  = 1'b1;
          evt_code = 8'hE1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdy_q <= 1'b0;
      st_q  <= S_IDLE;
      cnt_q <= 3'd0;
    end else begin
      rdy_q <= rx_ready;
      if (take && rx_error) begin
        st_q <= S_IDLE;
      end else if (dec_byte) begin
        case (st_q)
          S_IDLE: begin
            if (rx_data == 8'hE0)      st_q <= S_E0;
            else if (rx_data == 8'hF0) st_q <= S_F0;
            else if (rx_data == 8'hE1) begin
              st_q  <= S_E1SKIP;
              cnt_q <= 3'd0;
            end
          end
          S_E0:     st_q <= (rx_data == 8'hF0) ? S_E0F0 : S_IDLE;
          S_E1SKIP: begin
            if (cnt_q == 3'd6) st_q <= S_IDLE;
            else               cnt_q <= cnt_q + 3'd1;
          end
          default:  st_q <= S_IDLE;
        endcase
      end
    end
  end

  // Per-key held bits suppress typematic repeats from re-toggling a lock
  assign lk_sel   = {evt_code == 8'h58, evt_code == 8'h77, evt_code == 8'h7E} & {3{evt_we & ~evt_ext}};
  assign lock_tgl = lk_sel & ~held_q & {3{~evt_brk}};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mods_q  <= 4'd0;
      locks_q <= 3'd0;
      held_q  <= 3'd0;
    end else begin
      locks_q <= locks_q ^ lock_tgl;
      held_q  <= evt_brk ? (held_q & ~lk_sel) : (held_q | lk_sel);
      if (evt_we) begin
        if (!evt_ext && evt_code == 8'h12) mods_q[0] <= ~evt_brk;
        if (!evt_ext && evt_code == 8'h59) mods_q[1] <= ~evt_brk;
        if (evt_code == 8'h14)             mods_q[2] <= ~evt_brk;
        if (evt_code == 8'h11)             mods_q[3] <= ~evt_brk;
      end
    end
  end

  assign mods  = mods_q;
  assign locks = locks_q;

  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q, fill;
  logic        full, push, pop, drop;
  logic [9:0]  head;

  assign fill     = wr_q - rd_q;
  assign full     = (fill == (AW+1)'(FIFO_DEPTH));
  assign ev_valid = (wr_q != rd_q);
  assign pop      = ev_pop & ev_valid;
  assign push     = evt_we & (~full | pop);
  assign drop     = evt_we & full & ~pop;
  assign head     = mem_q[rd_q[AW-1:0]];
  assign ev_ext   = ev_valid & head[9];
  assign ev_break = ev_valid & head[8];
  assign ev_code  = ev_valid ? head[7:0] : 8'h00;
  assign overflow = ovf_q;

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {evt_ext, evt_brk, evt_code};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

`ifdef PS2_KBD_LED_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {L_IDLE, L_CMD, L_ACK1, L_VAL, L_ACK2} led_state_t;

  led_state_t    lst_q;
  logic          pend_q, send_req_q;
  logic [7:0]    tx_data_q;
  logic [TW-1:0] tmr_q;
  logic          in_ack;

  assign in_ack   = (lst_q == L_ACK1) || (lst_q == L_ACK2);
  assign led_eat  = byte_ok && in_ack && (rx_data == 8'hFA);
  assign send_req = send_req_q;
  assign tx_data  = tx_data_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lst_q      <= L_IDLE;
      pend_q     <= 1'b0;
      send_req_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tmr_q      <= '0;
    end else begin
      send_req_q <= 1'b0;
      case (lst_q)
        L_IDLE: if (pend_q && !tx_busy) begin
          lst_q  <= L_CMD;
          pend_q <= 1'b0;
        end
        L_CMD: begin
          send_req_q <= 1'b1;
          tx_data_q  <= 8'hED;
          tmr_q      <= '0;
          lst_q      <= L_ACK1;
        end
        L_ACK1, L_ACK2: begin
          // Any non-ack byte or a silent keyboard abandons this attempt and retries later
          if (byte_ok) begin
            if (rx_data == 8'hFA) begin
              lst_q <= (lst_q == L_ACK1) ? L_VAL : L_IDLE;
            end else begin
              lst_q  <= L_IDLE;
              pend_q <= 1'b1;
            end
          end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
            lst_q  <= L_IDLE;
            pend_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        L_VAL: if (!tx_busy) begin
          send_req_q <= 1'b1;
          tx_data_q  <= {5'b0, locks_q};
          tmr_q      <= '0;
          lst_q      <= L_ACK2;
        end
        default: lst_q <= L_IDLE;
      endcase
      if (|lock_tgl) pend_q <= 1'b1;
    end
  end
`else
  assign led_eat = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: decode, modifiers/locks, FIFO limits, error/reset recovery.
// LED protocol section is compiled only when PS2_KBD_LED_EN is defined.
module tb_ps2_kbd_decoder;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_error = 1'b0;
  logic       ev_valid, ev_ext, ev_break, overflow;
  logic [7:0] ev_code;
  logic       ev_pop = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] mods;
  logic [2:0] locks;
`ifdef PS2_KBD_LED_EN
  logic [7:0] tx_data;
  logic       send_req;
  logic       tx_busy = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  always #5 sys_clk = ~sys_clk;

  ps2_kbd_decoder #(.FIFO_DEPTH(4), .ACK_TIMEOUT(50)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
    .ev_pop(ev_pop), .overflow(overflow), .ovf_clr(ovf_clr),
    .mods(mods), .locks(locks)
`ifdef PS2_KBD_LED_EN
    , .tx_data(tx_data), .send_req(send_req), .tx_busy(tx_busy)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err = 1'b0);
    @(negedge sys_clk);
    rx_data  = b;
    rx_ready = 1'b1;
    rx_error = err;
    @(negedge sys_clk);
    rx_ready = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s [$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic pop_expect(input string tag, input logic ext, input logic brk, input logic [7:0] code);
    @(negedge sys_clk);
    check({tag, "_vld"}, ev_valid, 1);
    check({tag, "_ev"}, {ev_ext, ev_break, ev_code}, {ext, brk, code});
    ev_pop = 1'b1;
    @(negedge sys_clk);
    ev_pop = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (!ev_valid) break;
      ev_pop = 1'b1;
      @(negedge sys_clk);
      ev_pop = 1'b0;
    end
  endtask

`ifdef PS2_KBD_LED_EN
  task automatic expect_send(input string tag, input logic [7:0] exp);
    logic seen = 1'b0;
    logic [7:0] d = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (send_req) begin
        seen = 1'b1;
        d = tx_data;
        break;
      end
    end
    check({tag, "_seen"}, seen, 1);
    check({tag, "_data"}, d, exp);
  endtask
`endif

  initial begin
    repeat (2) @(negedge sys_clk);
    check("rst_state", {ev_valid, ev_code, ev_ext, ev_break, overflow, mods, locks}, 0);
    sys_rst_n = 1'b1;

    // First-event latency
    @(negedge sys_clk);
    rx_data = 8'h1C;
    rx_ready = 1'b1;
    check("lat_pre", ev_valid, 0);
    @(negedge sys_clk);
    rx_ready = 1'b0;
    check("lat_post", ev_valid, 1);
    pop_expect("make_1c", 0, 0, 8'h1C);
    send_seq('{8'hF0, 8'h1C});
    pop_expect("brk_1c", 0, 1, 8'h1C);
    send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
    pop_expect("e0_make", 1, 0, 8'h75);
    pop_expect("e0_brk", 1, 1, 8'h75);
    send_byte(8'hAA);
    @(negedge sys_clk);
    check("aa_drop", ev_valid, 0);

    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
    pop_expect("pause", 1, 0, 8'hE1);
    check("pause_once", ev_valid, 0);
    check("pause_num", locks, 3'b000);

    send_byte(8'h12);                 check("m_lsh", mods, 4'b0001); flush();
    send_seq('{8'hE0, 8'h14});        check("m_rctl", mods, 4'b0101); flush();
    send_byte(8'h11);                 check("m_alt", mods, 4'b1101); flush();
    send_seq('{8'hF0, 8'h12});        check("m_lsh_up", mods, 4'b1100); flush();
    send_seq('{8'hE0, 8'hF0, 8'h14}); check("m_ctl_up", mods, 4'b1000); flush();
    send_byte(8'h59);                 check("m_rsh", mods, 4'b1010); flush();
    send_seq('{8'hF0, 8'h11, 8'hF0, 8'h59}); check("m_clear", mods, 4'b0000); flush();

    send_seq('{8'h58, 8'h58, 8'hF0, 8'h58}); check("caps_once", locks, 3'b100); flush();
    send_seq('{8'h77, 8'hF0, 8'h77});         check("num_on", locks, 3'b110); flush();
    send_seq('{8'h77, 8'hF0, 8'h77});         check("num_off", locks, 3'b100); flush();

    // FIFO limits with depth 4
    send_seq('{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D});
    check("ovf_set", overflow, 1);
    check("full_head", ev_code, 8'h15);
    @(negedge sys_clk);
    ovf_clr = 1'b1;
    @(negedge sys_clk);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    rx_data = 8'h34;
    rx_ready = 1'b1;
    ev_pop = 1'b1;
    @(negedge sys_clk);
    rx_ready = 1'b0;
    ev_pop = 1'b0;
    check("pushpop_ovf", overflow, 0);
    @(negedge sys_clk);
    rx_data = 8'h3C;
    rx_ready = 1'b1;
    ovf_clr = 1'b1;
    @(negedge sys_clk);
    rx_ready = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    pop_expect("fifo0", 0, 0, 8'h16);
    pop_expect("fifo1", 0, 0, 8'h1D);
    pop_expect("fifo2", 0, 0, 8'h24);
    pop_expect("fifo3", 0, 0, 8'h34);
    check("fifo_empty", ev_valid, 0);
    @(negedge sys_clk);
    ovf_clr = 1'b1;
    @(negedge sys_clk);
    ovf_clr = 1'b0;

    // Error aborts a pending prefix
    send_byte(8'hF0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h1C);
    pop_expect("err_abort", 0, 0, 8'h1C);
    check("err_noev", ev_valid, 0);

    // Reset mid-prefix with a queued event
    send_seq('{8'h1C, 8'hE0});
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("rst_empty", {ev_valid, locks}, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    send_byte(8'h75);
    pop_expect("rst_prefix", 0, 0, 8'h75);

`ifdef PS2_KBD_LED_EN
    send_seq('{8'h58, 8'h58, 8'hF0, 8'h58});
    flush();
    check("led_locks", locks, 3'b100);
    expect_send("led_cmd", 8'hED);
    send_byte(8'hFA);
    expect_send("led_val", 8'h04);
    send_byte(8'hFA);
    begin
      logic extra = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge sys_clk);
        if (send_req || ev_valid) extra = 1'b1;
      end
      check("led_idle", extra, 0);
    end
    send_seq('{8'h7E, 8'hF0, 8'h7E});
    flush();
    check("led_scroll", locks, 3'b101);
    expect_send("led_try1", 8'hED);
    expect_send("led_retry", 8'hED);
    send_byte(8'hFA);
    expect_send("led_val2", 8'h05);
    send_byte(8'hFA);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
